// File: rtl/n2_frf_ecc_pkg.sv
// Shared constants, scrub FSM state and per-half SEC-DED helpers for the FRF read-path checker.
// Each 32b half uses a Hamming code over positions 1..38 plus an overall parity bit.
package n2_frf_ecc_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ECC_W  = 14;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned HECC_W = 7;
  localparam int unsigned TID_W  = 3;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic [1:0] {StIdle, StReq, StWait} scrub_st_e;

  typedef struct packed {
    logic              ue;
    logic              port;
    logic [TID_W-1:0]  tid;
    logic [ADDR_W-1:0] addr;
    logic [ECC_W-1:0]  syn;
  } err_log_t;

  // Data bits occupy the non-power-of-two positions 1..38, LSB first.
  function automatic logic [5:0] ham_syn32(input logic [HALF_W-1:0] d);
    logic [5:0] s;
    logic [5:0] k;
    s = '0;
    k = '0;
    for (int unsigned p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k[4:0]]) s = s ^ 6'(p);
        k = k + 6'd1;
      end
    end
    return s;
  endfunction

  // {overall parity, check bits[5:0]}
  function automatic logic [HECC_W-1:0] ecc_gen32(input logic [HALF_W-1:0] d);
    logic [5:0] c;
    c = ham_syn32(d);
    return {^{d, c}, c};
  endfunction

  // Returns {syn[6:0] = {parity error, hamming syndrome}, ce, ue}.
  function automatic logic [8:0] ecc_chk32(input logic [HALF_W-1:0] d,
                                           input logic [HECC_W-1:0] e);
    logic [5:0] s;
    logic       par;
    s   = ham_syn32(d) ^ e[5:0];
    par = ^{d, e};
    return {par, s, par, ~par & (s != 6'd0)};
  endfunction

endpackage

// File: rtl/n2_frf_ecc_chk_scrub_if.sv
// Bus bundle between the FRF read path, the FGU, the w2 write-port mux and the error logger.
// FRF_ECC_ERR_INJECT_EN adds the error-injection inputs.
interface n2_frf_ecc_chk_scrub_if;
  import n2_frf_ecc_pkg::*;

`ifdef FRF_ECC_ERR_INJECT_EN
  logic                    inj_en;
  logic                    inj_port;
  logic [DATA_W+ECC_W-1:0] inj_mask;
`endif
  logic [TID_W-1:0]  r_tid;
  logic              r1_valid;
  logic [ADDR_W-1:0] r1_addr;
  logic              r2_valid;
  logic [ADDR_W-1:0] r2_addr;
  logic [DATA_W-1:0] frf_r1_data;
  logic [ECC_W-1:0]  frf_r1_ecc;
  logic [DATA_W-1:0] frf_r2_data;
  logic [ECC_W-1:0]  frf_r2_ecc;
  logic [DATA_W-1:0] fgu_r1_data;
  logic [DATA_W-1:0] fgu_r2_data;
  logic [1:0]        fgu_rd_vld;
  logic              frf_stall;
  logic              scr_w_req;
  logic              scr_w_gnt;
  logic [TID_W-1:0]  scr_w_tid;
  logic [ADDR_W-1:0] scr_w_addr;
  logic [1:0]        scr_w_valid;
  logic [DATA_W-1:0] scr_w_data;
  logic [ECC_W-1:0]  scr_w_ecc;
  logic              err_vld;
  logic              err_ue;
  logic              err_port;
  logic [TID_W-1:0]  err_tid;
  logic [ADDR_W-1:0] err_addr;
  logic [ECC_W-1:0]  err_syn;
  logic              err_ovf;
  logic              err_ack;

  modport master (
`ifdef FRF_ECC_ERR_INJECT_EN
    output inj_en, inj_port, inj_mask,
`endif
    output r_tid, r1_valid, r1_addr, r2_valid, r2_addr,
    output frf_r1_data, frf_r1_ecc, frf_r2_data, frf_r2_ecc, scr_w_gnt, err_ack,
    input  fgu_r1_data, fgu_r2_data, fgu_rd_vld, frf_stall,
    input  scr_w_req, scr_w_tid, scr_w_addr, scr_w_valid, scr_w_data, scr_w_ecc,
    input  err_vld, err_ue, err_port, err_tid, err_addr, err_syn, err_ovf
  );

  modport slave (
`ifdef FRF_ECC_ERR_INJECT_EN
    input  inj_en, inj_port, inj_mask,
`endif
    input  r_tid, r1_valid, r1_addr, r2_valid, r2_addr,
    input  frf_r1_data, frf_r1_ecc, frf_r2_data, frf_r2_ecc, scr_w_gnt, err_ack,
    output fgu_r1_data, fgu_r2_data, fgu_rd_vld, frf_stall,
    output scr_w_req, scr_w_tid, scr_w_addr, scr_w_valid, scr_w_data, scr_w_ecc,
    output err_vld, err_ue, err_port, err_tid, err_addr, err_syn, err_ovf
  );

endinterface

// File: rtl/n2_frf_ecc_cor32.sv
// Combinational SEC-DED check and single-bit correction of one 32b half.
module n2_frf_ecc_cor32
  import n2_frf_ecc_pkg::*;
(
  input  logic [HALF_W-1:0] data_i,
  input  logic [HECC_W-1:0] ecc_i,
  output logic [HALF_W-1:0] data_o,
  output logic [HECC_W-1:0] syn_o,
  output logic              ce_o,
  output logic              ue_o
);

  logic [8:0] chk;
  logic [5:0] k;

  always_comb begin
    chk    = ecc_chk32(data_i, ecc_i);
    data_o = data_i;
    k      = '0;
    // A syndrome pointing at a check bit or the parity bit leaves the data untouched.
    for (int unsigned p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (chk[1] && (chk[7:2] == 6'(p))) data_o[k[4:0]] = ~data_i[k[4:0]];
        k = k + 6'd1;
      end
    end
  end

  assign syn_o = chk[8:2];
  assign ce_o  = chk[1];
  assign ue_o  = chk[0];

endmodule

// File: rtl/n2_frf_ecc_chk_scrub.sv
// FRF read-path ECC checker, FGU delivery, error log and write-back scrub sequencer.
// FRF_ECC_ERR_INJECT_EN enables XOR error injection ahead of the checker.
module n2_frf_ecc_chk_scrub
  import n2_frf_ecc_pkg::*;
#(
  parameter int unsigned SCRUB_WAIT = 2
) (
  input logic                   l2clk,
  input logic                   reset,
  n2_frf_ecc_chk_scrub_if.slave bus
);

  localparam int unsigned CntW = (SCRUB_WAIT > 1) ? $clog2(SCRUB_WAIT) : 1;

  logic [1:0]             rd_vld_q;
  logic [1:0][ADDR_W-1:0] rd_addr_q;
  logic [TID_W-1:0]       rd_tid_q;
  logic [1:0][DATA_W-1:0] chk_data, cor_data, fgu_data_q;
  logic [1:0][ECC_W-1:0]  chk_ecc, syn;
  logic [1:0][1:0]        h_ce, h_ue;
  logic [1:0]             p_ce, p_ue, p_err, fgu_vld_q;

  always_ff @(posedge l2clk) begin
    if (reset) begin
      rd_vld_q  <= '0;
      rd_addr_q <= '0;
      rd_tid_q  <= '0;
    end else begin
      rd_vld_q  <= {bus.r2_valid, bus.r1_valid};
      rd_addr_q <= {bus.r2_addr, bus.r1_addr};
      rd_tid_q  <= bus.r_tid;
    end
  end

`ifdef FRF_ECC_ERR_INJECT_EN
  logic inj_done_q, inj_act;
  assign inj_act = bus.inj_en & ~inj_done_q;

  always_comb begin
    {chk_ecc[0], chk_data[0]} = {bus.frf_r1_ecc, bus.frf_r1_data};
    {chk_ecc[1], chk_data[1]} = {bus.frf_r2_ecc, bus.frf_r2_data};
    if (inj_act && bus.inj_port) begin
      {chk_ecc[1], chk_data[1]} = {bus.frf_r2_ecc, bus.frf_r2_data} ^ bus.inj_mask;
    end else if (inj_act) begin
      {chk_ecc[0], chk_data[0]} = {bus.frf_r1_ecc, bus.frf_r1_data} ^ bus.inj_mask;
    end
  end

  // One-shot: stays spent until inj_en is dropped.
  always_ff @(posedge l2clk) begin
    if (reset || !bus.inj_en)                   inj_done_q <= 1'b0;
    else if (inj_act && rd_vld_q[bus.inj_port]) inj_done_q <= 1'b1;
  end
`else
  assign chk_data = {bus.frf_r2_data, bus.frf_r1_data};
  assign chk_ecc  = {bus.frf_r2_ecc, bus.frf_r1_ecc};
`endif

  for (genvar p = 0; p < 2; p++) begin : g_port
    for (genvar h = 0; h < 2; h++) begin : g_half
      n2_frf_ecc_cor32 u_cor (
        .data_i (chk_data[p][h*HALF_W +: HALF_W]),
        .ecc_i  (chk_ecc[p][h*HECC_W +: HECC_W]),
        .data_o (cor_data[p][h*HALF_W +: HALF_W]),
        .syn_o  (syn[p][h*HECC_W +: HECC_W]),
        .ce_o   (h_ce[p][h]),
        .ue_o   (h_ue[p][h])
      );
    end
    assign p_ue[p] = rd_vld_q[p] & (|h_ue[p]);
    assign p_ce[p] = rd_vld_q[p] & ~(|h_ue[p]) & (|h_ce[p]);
  end
  assign p_err = p_ce | p_ue;

  always_ff @(posedge l2clk) begin
    if (reset) begin
      fgu_vld_q  <= '0;
      fgu_data_q <= '0;
    end else begin
      fgu_vld_q <= rd_vld_q & ~p_ue;
      for (int p = 0; p < 2; p++) begin
        if (rd_vld_q[p]) fgu_data_q[p] <= cor_data[p];
      end
    end
  end

  // Scrub sequencer; the buffer is only refilled from IDLE so it doubles as the empty flag.
  scrub_st_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              scr_load, scr_sel, scr_req;
  logic [TID_W-1:0]  buf_tid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_data_q;
  logic [ECC_W-1:0]  buf_ecc_q, scr_ecc_new;

  assign scr_sel     = ~p_ce[0];
  assign scr_ecc_new = {ecc_gen32(cor_data[scr_sel][DATA_W-1:HALF_W]),
                        ecc_gen32(cor_data[scr_sel][HALF_W-1:0])};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scr_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|p_ce) begin
          scr_load = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (bus.scr_w_gnt) begin
          state_d = StWait;
          cnt_d   = CntW'(SCRUB_WAIT - 1);
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge l2clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      buf_tid_q  <= '0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      buf_ecc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (scr_load) begin
        buf_tid_q  <= rd_tid_q;
        buf_addr_q <= rd_addr_q[scr_sel];
        buf_data_q <= cor_data[scr_sel];
        buf_ecc_q  <= scr_ecc_new;
      end
    end
  end

  // Error log: UE beats CE, then port 1 beats port 2; everything not captured is an overflow.
  err_log_t log_q, log_d;
  logic     log_vld_q, log_vld_d, ovf_q, ovf_d, esel;

  always_comb begin
    esel      = p_ue[0] ? 1'b0 : (p_ue[1] ? 1'b1 : ~p_ce[0]);
    log_vld_d = log_vld_q & ~bus.err_ack;
    ovf_d     = ovf_q & ~bus.err_ack;
    log_d     = bus.err_ack ? '0 : log_q;
    if (|p_err) begin
      if (!log_vld_q || bus.err_ack) begin
        log_vld_d = 1'b1;
        ovf_d     = &p_err;
        log_d     = '{ue: p_ue[esel], port: esel, tid: rd_tid_q, addr: rd_addr_q[esel],
                      syn: syn[esel]};
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge l2clk) begin
    if (reset) begin
      log_q     <= '0;
      log_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      log_q     <= log_d;
      log_vld_q <= log_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign scr_req         = (state_q == StReq);
  assign bus.frf_stall   = (state_q != StIdle);
  assign bus.scr_w_req   = scr_req;
  assign bus.scr_w_tid   = scr_req ? buf_tid_q : '0;
  assign bus.scr_w_addr  = scr_req ? buf_addr_q : '0;
  assign bus.scr_w_valid = {2{scr_req}};
  assign bus.scr_w_data  = scr_req ? buf_data_q : '0;
  assign bus.scr_w_ecc   = scr_req ? buf_ecc_q : '0;
  assign bus.fgu_r1_data = fgu_data_q[0];
  assign bus.fgu_r2_data = fgu_data_q[1];
  assign bus.fgu_rd_vld  = fgu_vld_q;
  assign bus.err_vld     = log_vld_q;
  assign bus.err_ue      = log_q.ue;
  assign bus.err_port    = log_q.port;
  assign bus.err_tid     = log_q.tid;
  assign bus.err_addr    = log_q.addr;
  assign bus.err_syn     = log_q.syn;
  assign bus.err_ovf     = ovf_q;

endmodule
